// File: rtl/protocol_responder.sv
// Two-byte UART command responder: (cmd, addr) in, one timed sensor transaction, (code, payload) out.
// Latency: addr byte -> DECODE 1 cycle; sensor_ack -> byte-0 tx_start 2 cycles; stalls on tx_active; rx bytes dropped while busy.
module protocol_responder #(
  parameter int unsigned FRAME_TIMEOUT  = 50_000_000,
  parameter int unsigned SENSOR_TIMEOUT = 100_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       sensor_req,
  output logic [4:0] sensor_addr,
  output logic [1:0] sensor_sel,
  input  logic       sensor_ack,
  input  logic       sensor_err,
  input  logic [7:0] sensor_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, WAIT_ADDR, DECODE, SENSOR_REQ, SENSOR_WAIT,
    SEND_B0, WAIT_B0, SEND_B1, WAIT_B1
  } state_t;

  // Counters hold (limit - 1) on the cycle whose edge reaches the limit.
  localparam logic [31:0] FRAME_LAST  = 32'(FRAME_TIMEOUT - 1);
  localparam logic [31:0] SENSOR_LAST = 32'(SENSOR_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  resp0_q, resp0_d;
  logic [7:0]  resp1_q, resp1_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] sens_cnt_q, sens_cnt_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        sensor_req_q, sensor_req_d;
  logic [4:0]  sensor_addr_q, sensor_addr_d;
  logic [1:0]  sensor_sel_q, sensor_sel_d;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    resp0_d       = resp0_q;
    resp1_d       = resp1_q;
    frame_cnt_d   = frame_cnt_q;
    sens_cnt_d    = sens_cnt_q;
    tx_start_d    = 1'b0;
    tx_byte_d     = tx_byte_q;
    sensor_req_d  = 1'b0;
    sensor_addr_d = sensor_addr_q;
    sensor_sel_d  = sensor_sel_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          cmd_d       = rx_byte;
          frame_cnt_d = '0;
          state_d     = WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        frame_cnt_d = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 32'd1;
        // An address arriving on the timeout edge still wins.
        if (rx_valid) begin
          addr_d  = rx_byte;
          state_d = DECODE;
        end else if (frame_cnt_q >= FRAME_LAST) begin
          cmd_d   = '0;
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (!(cmd_q inside {8'h01, 8'h02, 8'h03})) begin
          resp0_d = 8'hE0;
          resp1_d = cmd_q;
          state_d = SEND_B0;
        end else if (addr_q > 8'h1F) begin
          resp0_d = 8'hE1;
          resp1_d = addr_q;
          state_d = SEND_B0;
        end else begin
          sensor_sel_d  = cmd_q[1:0];
          sensor_addr_d = addr_q[4:0];
          sensor_req_d  = 1'b1;
          state_d       = SENSOR_REQ;
        end
      end
      SENSOR_REQ: begin
        sens_cnt_d = '0;
        state_d    = SENSOR_WAIT;
      end
      SENSOR_WAIT: begin
        sens_cnt_d = (sens_cnt_q == '1) ? sens_cnt_q : sens_cnt_q + 32'd1;
        if (sensor_ack) begin
          state_d = SEND_B0;
          if (sensor_err) begin
            resp0_d = 8'h1F;
            resp1_d = addr_q;
          end else begin
            case (cmd_q)
              8'h01:   begin resp0_d = 8'h09; resp1_d = sensor_data; end
              8'h02:   begin resp0_d = 8'h08; resp1_d = sensor_data; end
              default: begin resp0_d = 8'h07; resp1_d = addr_q;      end
            endcase
          end
        end else if (sens_cnt_q >= SENSOR_LAST) begin
          resp0_d = 8'hE2;
          resp1_d = addr_q;
          state_d = SEND_B0;
        end
      end
      SEND_B0: begin
        if (!tx_active) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp0_q;
          state_d    = WAIT_B0;
        end
      end
      WAIT_B0: begin
        if (tx_done) state_d = SEND_B1;
      end
      SEND_B1: begin
        if (!tx_active) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp1_q;
          state_d    = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      addr_q        <= '0;
      resp0_q       <= '0;
      resp1_q       <= '0;
      frame_cnt_q   <= '0;
      sens_cnt_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_byte_q     <= '0;
      sensor_req_q  <= 1'b0;
      sensor_addr_q <= '0;
      sensor_sel_q  <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      resp0_q       <= resp0_d;
      resp1_q       <= resp1_d;
      frame_cnt_q   <= frame_cnt_d;
      sens_cnt_q    <= sens_cnt_d;
      tx_start_q    <= tx_start_d;
      tx_byte_q     <= tx_byte_d;
      sensor_req_q  <= sensor_req_d;
      sensor_addr_q <= sensor_addr_d;
      sensor_sel_q  <= sensor_sel_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign sensor_req  = sensor_req_q;
  assign sensor_addr = sensor_addr_q;
  assign sensor_sel  = sensor_sel_q;
  assign busy        = !(state_q == IDLE || state_q == WAIT_ADDR);

endmodule

// File: tb/tb_protocol_responder.sv
// Bench for protocol_responder: directed frames, transmitter/sensor models, queue-based scoreboard.
module tb_protocol_responder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       sensor_req;
  logic [4:0] sensor_addr;
  logic [1:0] sensor_sel;
  logic       sensor_ack = 1'b0;
  logic       sensor_err = 1'b0;
  logic [7:0] sensor_data = '0;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_tx[$];
  int exp_sens[$];

  // Sensor model knobs: cycles from sensor_req to ack, returned data and fault flag.
  int         s_delay = 2;
  logic [7:0] s_data  = '0;
  logic       s_err   = 1'b0;

  protocol_responder #(.FRAME_TIMEOUT(50), .SENSOR_TIMEOUT(100)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .sensor_req(sensor_req), .sensor_addr(sensor_addr), .sensor_sel(sensor_sel),
    .sensor_ack(sensor_ack), .sensor_err(sensor_err), .sensor_data(sensor_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transmitter model: busy for four cycles after tx_start, then a one-cycle tx_done.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_start) begin
        tx_active = 1'b1;
        repeat (4) @(negedge clock);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clock);
        tx_done   = 1'b0;
      end
    end
  end

  // Sensor model: ack lands on the posedge s_delay cycles after the sensor_req cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (sensor_req) begin
        repeat (s_delay) @(negedge clock);
        sensor_ack  = 1'b1;
        sensor_data = s_data;
        sensor_err  = s_err;
        @(negedge clock);
        sensor_ack  = 1'b0;
        sensor_data = '0;
        sensor_err  = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT emits tx_start or sensor_req.
  initial begin
    logic prev_tx = 1'b0;
    logic prev_sr = 1'b0;
    int   e;
    forever begin
      @(negedge clock);
      if (tx_start) begin
        check("tx_start_width", int'(prev_tx), 0);
        if (exp_tx.size() == 0) check("tx_unexpected_start", int'(tx_start), 0);
        else begin
          e = exp_tx.pop_front();
          check("tx_byte", int'(tx_byte), e);
        end
      end
      if (sensor_req) begin
        check("sensor_req_width", int'(prev_sr), 0);
        if (exp_sens.size() == 0) check("sensor_unexpected_req", int'(sensor_req), 0);
        else begin
          e = exp_sens.pop_front();
          check("sensor_addr_sel", int'({sensor_addr, sensor_sel}), e);
        end
      end
      prev_tx = tx_start;
      prev_sr = sensor_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Caller is at a negedge; the byte is sampled by the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_byte  = '0;
  endtask

  // gap = number of posedges between sampling the command and sampling the address.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input int gap);
    send_byte(c);
    repeat (gap - 1) @(negedge clock);
    send_byte(a);
  endtask

  task automatic expect_tx(input int b0, input int b1);
    exp_tx.push_back(b0);
    exp_tx.push_back(b1);
  endtask

  task automatic expect_sens(input int addr, input int sel);
    exp_sens.push_back((addr << 2) | sel);
  endtask

  task automatic drain(input string name);
    int done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (exp_tx.size() == 0 && exp_sens.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    check(name, done, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"},    int'(tx_start),    0);
    check({tag, "_tx_byte"},     int'(tx_byte),     0);
    check({tag, "_sensor_req"},  int'(sensor_req),  0);
    check({tag, "_sensor_addr"}, int'(sensor_addr), 0);
    check({tag, "_sensor_sel"},  int'(sensor_sel),  0);
    check({tag, "_busy"},        int'(busy),        0);
  endtask

  initial begin
    int got_done;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Temperature read
    s_delay = 3; s_data = 8'h1A; s_err = 1'b0;
    expect_sens(5, 1); expect_tx(8'h09, 8'h1A);
    send_frame(8'h01, 8'h05, 1);
    drain("temp_read");

    // Unknown command, then out-of-range address
    expect_tx(8'hE0, 8'h04);
    send_frame(8'h04, 8'h00, 1);
    drain("bad_cmd");
    expect_tx(8'hE1, 8'h20);
    send_frame(8'h02, 8'h20, 1);
    drain("bad_addr");
    expect_tx(8'hE0, 8'h00);
    send_frame(8'h00, 8'h00, 1);
    drain("cmd_zero");

    // Sensor timeout; the ack one cycle past the limit must be ignored
    s_delay = 101;
    expect_sens(2, 3); expect_tx(8'hE2, 8'h02);
    send_frame(8'h03, 8'h02, 1);
    drain("sensor_timeout");
    repeat (20) @(negedge clock);
    check("late_ack_idle", int'(busy), 0);

    // Ack on the very cycle the sensor counter reaches its limit wins
    s_delay = 100;
    expect_sens(5'h1F, 3); expect_tx(8'h07, 8'h1F);
    send_frame(8'h03, 8'h1F, 1);
    drain("ack_at_limit");

    // Frame timeout with no address, then a fresh humidity frame
    s_delay = 2; s_data = 8'h3C;
    send_byte(8'h01);
    repeat (60) @(negedge clock);
    check("frame_timeout_busy", int'(busy), 0);
    expect_sens(1, 2); expect_tx(8'h08, 8'h3C);
    send_frame(8'h02, 8'h01, 1);
    drain("after_frame_timeout");

    // Address on the timeout edge is accepted
    s_delay = 1; s_data = 8'h77;
    expect_sens(3, 2); expect_tx(8'h08, 8'h77);
    send_frame(8'h02, 8'h03, 50);
    drain("addr_at_frame_limit");

    // One edge later it is taken as a new command instead
    s_data = 8'h5A;
    expect_sens(3, 1); expect_tx(8'h09, 8'h5A);
    send_frame(8'h02, 8'h01, 51);
    send_byte(8'h03);
    drain("addr_past_frame_limit");

    // Sensor fault
    s_delay = 5; s_data = 8'h99; s_err = 1'b1;
    expect_sens(5'h1F, 1); expect_tx(8'h1F, 8'h1F);
    send_frame(8'h01, 8'h1F, 1);
    drain("sensor_err");
    s_err = 1'b0;

    // A byte arriving while busy is dropped
    s_delay = 30; s_data = 8'h44;
    expect_sens(6, 2); expect_tx(8'h08, 8'h44);
    send_frame(8'h02, 8'h06, 1);
    repeat (5) @(negedge clock);
    send_byte(8'h03);
    drain("rx_while_busy");

    // Reset between byte-0 tx_done and byte-1 tx_start
    exp_tx.push_back(8'hE0);
    send_frame(8'h04, 8'h00, 1);
    got_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      if (tx_done) begin
        got_done = 1;
        break;
      end
    end
    check("reset_test_tx_done_seen", got_done, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("midreset_pending_tx", exp_tx.size(), 0);
    check("midreset_busy", int'(busy), 0);

    // Recovery after reset
    s_delay = 2;
    expect_sens(4, 3); expect_tx(8'h07, 8'h04);
    send_frame(8'h03, 8'h04, 1);
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
